// File: rtl/req_latch4_pkg.sv
// rtl/req_latch4_pkg.sv - shared types and constants for the req_latch4 request collector
//
// Contents:
//   N_REQ     number of request lines
//   IDX_W     width of a request index
//   state_t   offer FSM state encoding (S_IDLE, S_OFFER)
//   popcount4 number of set bits in a 4-bit vector

package req_latch4_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    function automatic logic [2:0] popcount4(input logic [N_REQ-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/req_latch4_rr_pick4.sv
// rtl/req_latch4_rr_pick4.sv - combinational round-robin picker over four request bits
//
// Ports:
//   i_req    in  4  request vector, bit n = line n
//   i_last   in  2  index served most recently (lowest priority)
//   o_found  out 1  at least one request bit is set
//   o_idx    out 2  first set bit scanning upward from i_last+1, modulo 4

module rr_pick4
    import req_latch4_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        cand    = '0;
        o_idx   = '0;
        o_found = |i_req;
        // Walk from the farthest candidate back to the nearest so the
        // nearest set bit after i_last is the last assignment to stick.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = i_last + IDX_W'(k);
            if (i_req[cand]) begin
                o_idx = cand;
            end
        end
    end

endmodule

// File: rtl/req_latch4.sv
// rtl/req_latch4.sv - four-line sticky request collector with round-robin offer and drop counter
//
// Parameters:
//   EDGE   1 = capture rising edges of each line, 0 = capture while line is high
//   CNT_W  width of the saturating drop counter
// Ports:
//   i_clk       in  1      clock
//   i_rst       in  1      synchronous active-high reset
//   i_a..i_d    in  1 each request lines 0..3
//   i_ready     in  1      consumer accepts the offered index
//   o_valid     out 1      an index is being offered
//   o_idx       out 2      offered request index
//   o_pending   out 4      sticky pending flags
//   o_any       out 1      OR of the pending flags
//   o_drop_cnt  out CNT_W  saturating count of lost capture events

module req_latch4
    import req_latch4_pkg::*;
#(
    parameter bit EDGE  = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_c,
    input  logic             i_d,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [N_REQ-1:0] o_pending,
    output logic             o_any,
    output logic [CNT_W-1:0] o_drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] prev_q, prev_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    state_t           state_q, state_d;

    logic [N_REQ-1:0] cap;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] drop;
    logic             hs;
    logic [CNT_W+2:0] cnt_sum;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    assign req = {i_d, i_c, i_b, i_a};

    rr_pick4 u_pick (
        .i_req   (pending_q),
        .i_last  (last_q),
        .o_found (pick_found),
        .o_idx   (pick_idx)
    );

    always_comb begin
        prev_d = req;

        if (EDGE) begin
            cap = req & ~prev_q;
        end else begin
            cap = req;
        end

        hs  = (state_q == S_OFFER) && i_ready;
        clr = '0;
        if (hs) begin
            clr[idx_q] = 1'b1;
        end

        // A fresh capture on the line being cleared keeps the flag set.
        pending_d = (pending_q & ~clr) | cap;

        // An event is lost only if it lands on a flag that stays set anyway.
        drop    = cap & pending_q & ~clr;
        cnt_sum = {3'b000, cnt_q} + {{CNT_W{1'b0}}, popcount4(drop)};
        if (cnt_sum > {3'b000, CNT_MAX}) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
        end

        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (i_ready) begin
                    last_d  = idx_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // prev loads the lines even in reset so a line held high through
        // reset does not look like a new edge afterwards.
        prev_q <= prev_d;
        if (i_rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            state_q   <= S_IDLE;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            state_q   <= state_d;
        end
    end

    assign o_valid    = (state_q == S_OFFER);
    assign o_idx      = idx_q;
    assign o_pending  = pending_q;
    assign o_any      = |pending_q;
    assign o_drop_cnt = cnt_q;

endmodule

// File: tb/tb_req_latch4.sv
// tb/tb_req_latch4.sv - self-checking bench for req_latch4 with a grant-order scoreboard

module tb_req_latch4;

    logic clk;
    logic rst;
    logic a, b, c, d;
    logic rdy;

    logic       m_valid;
    logic [1:0] m_idx;
    logic [3:0] m_pending;
    logic       m_any;
    logic [7:0] m_cnt;

    logic       s_valid;
    logic [1:0] s_idx;
    logic [3:0] s_pending;
    logic       s_any;
    logic [1:0] s_cnt;

    logic       l_valid;
    logic [1:0] l_idx;
    logic [3:0] l_pending;
    logic       l_any;
    logic [7:0] l_cnt;

    int total;
    int bad;
    int sb_q[$];

    req_latch4 #(.EDGE(1'b1), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
        .i_ready(rdy), .o_valid(m_valid), .o_idx(m_idx),
        .o_pending(m_pending), .o_any(m_any), .o_drop_cnt(m_cnt)
    );

    req_latch4 #(.EDGE(1'b1), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
        .i_ready(rdy), .o_valid(s_valid), .o_idx(s_idx),
        .o_pending(s_pending), .o_any(s_any), .o_drop_cnt(s_cnt)
    );

    req_latch4 #(.EDGE(1'b0), .CNT_W(8)) dut_lvl (
        .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
        .i_ready(rdy), .o_valid(l_valid), .o_idx(l_idx),
        .o_pending(l_pending), .o_any(l_any), .o_drop_cnt(l_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Handshake monitor: inputs settle shortly after posedge, so at negedge
    // valid&ready tells whether the coming edge completes a grant.
    always @(negedge clk) begin
        if (!rst && m_valid && rdy) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL grant_unexpected: got idx=%0d, scoreboard empty", m_idx);
            end else begin
                if (m_idx !== 2'(sb_q[0])) begin
                    bad++;
                    $display("FAIL grant_order: got idx=%0d, want idx=%0d", m_idx, sb_q[0]);
                end
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {a, b, c, d} = 4'b0000;
        rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: %0d grants outstanding, want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {a, c, d} = 3'b000;
        b   = 1'b1;
        rdy = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (m_pending !== 4'b0000 || m_any !== 1'b0 || m_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold_b cycle %0d: pending=%b any=%b valid=%b, want 0000/0/0",
                         i, m_pending, m_any, m_valid);
            end
        end
        total++;
        if (m_idx !== 2'd0 || m_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_values: idx=%0d drop=%0d, want 0/0", m_idx, m_cnt);
        end
        b = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        rdy = 1'b1;
        sb_q.push_back(2);
        c = 1'b1;
        tick();
        c = 1'b0;
        total++;
        if (m_any !== 1'b1 || m_pending !== 4'b0100 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_capture: any=%b pending=%b valid=%b, want 1/0100/0",
                     m_any, m_pending, m_valid);
        end
        tick();
        total++;
        if (m_valid !== 1'b1 || m_idx !== 2'd2) begin
            bad++;
            $display("FAIL single_offer: valid=%b idx=%0d, want 1/2", m_valid, m_idx);
        end
        tick();
        total++;
        if (m_valid !== 1'b0 || m_any !== 1'b0 || m_pending !== 4'b0000) begin
            bad++;
            $display("FAIL single_clear: valid=%b any=%b pending=%b, want 0/0/0000",
                     m_valid, m_any, m_pending);
        end
        rdy = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        rdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) sb_q.push_back(i);
            {a, b, c, d} = 4'b1111;
            tick();
            {a, b, c, d} = 4'b0000;
            drain("round_robin");
            tick();
            total++;
            if (m_pending !== 4'b0000 || m_valid !== 1'b0) begin
                bad++;
                $display("FAIL rr_empty round %0d: pending=%b valid=%b, want 0000/0",
                         r, m_pending, m_valid);
            end
        end
        rdy = 1'b0;
    endtask

    task automatic test_set_wins();
        do_reset();
        sb_q.push_back(0);
        sb_q.push_back(1);
        sb_q.push_back(0);
        a = 1'b1;
        b = 1'b1;
        tick();
        a = 1'b0;
        b = 1'b0;
        tick();
        tick();
        total++;
        if (m_valid !== 1'b1 || m_idx !== 2'd0) begin
            bad++;
            $display("FAIL setwin_offer: valid=%b idx=%0d, want 1/0", m_valid, m_idx);
        end
        rdy = 1'b1;
        a   = 1'b1;
        tick();
        a = 1'b0;
        total++;
        if (m_pending !== 4'b0011 || m_cnt !== 8'd0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL setwin_hold: pending=%b drop=%0d valid=%b, want 0011/0/0",
                     m_pending, m_cnt, m_valid);
        end
        drain("set_wins");
        tick();
        total++;
        if (m_pending !== 4'b0000) begin
            bad++;
            $display("FAIL setwin_empty: pending=%b, want 0000", m_pending);
        end
        rdy = 1'b0;
    endtask

    task automatic test_drop_sat();
        logic [1:0] want_s[5];
        want_s = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        d = 1'b1;
        tick();
        d = 1'b0;
        tick();
        total++;
        if (s_pending !== 4'b1000 || s_cnt !== 2'd0) begin
            bad++;
            $display("FAIL drop_setup: pending=%b drop=%0d, want 1000/0", s_pending, s_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            d = 1'b1;
            tick();
            total++;
            if (s_cnt !== want_s[i]) begin
                bad++;
                $display("FAIL drop_sat step %0d: drop=%0d, want %0d", i, s_cnt, want_s[i]);
            end
            d = 1'b0;
            tick();
        end
        total++;
        if (m_cnt !== 8'd5) begin
            bad++;
            $display("FAIL drop_wide: drop=%0d, want 5", m_cnt);
        end
    endtask

    task automatic test_level_reset();
        do_reset();
        a = 1'b1;
        tick();
        tick();
        total++;
        if (l_valid !== 1'b1 || l_idx !== 2'd0 || l_pending !== 4'b0001) begin
            bad++;
            $display("FAIL level_offer: valid=%b idx=%0d pending=%b, want 1/0/0001",
                     l_valid, l_idx, l_pending);
        end
        tick();
        tick();
        total++;
        if (l_valid !== 1'b1 || l_idx !== 2'd0 || l_cnt !== 8'd3) begin
            bad++;
            $display("FAIL level_hold: valid=%b idx=%0d drop=%0d, want 1/0/3",
                     l_valid, l_idx, l_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (l_valid !== 1'b0 || l_idx !== 2'd0 || l_pending !== 4'b0000 ||
            l_any !== 1'b0 || l_cnt !== 8'd0) begin
            bad++;
            $display("FAIL level_reset: valid=%b idx=%0d pending=%b any=%b drop=%0d, want 0/0/0000/0/0",
                     l_valid, l_idx, l_pending, l_any, l_cnt);
        end
        tick();
        total++;
        if (l_pending !== 4'b0001 || l_any !== 1'b1 || l_valid !== 1'b0) begin
            bad++;
            $display("FAIL level_recapture: pending=%b any=%b valid=%b, want 0001/1/0",
                     l_pending, l_any, l_valid);
        end
        a = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        {a, b, c, d} = 4'b0000;
        rdy   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_set_wins();
        test_drop_sat();
        test_level_reset();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: %0d entries, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
